// File: rtl/wb_port_arbiter_pkg.sv
// Shared defaults for the writeback port arbiter.
// Build option: define WB_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
package wb_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;

  // Architectural zero register; writes to it are suppressed.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_port_arbiter_rr_picker.sv
// Rotating priority picker: first valid bit at or after start, wrapping modulo N.
module wb_port_arbiter_rr_picker #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk positions start, start+1, ... and take the first valid one.
  always_comb begin
    int p;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    p     = 0;
    for (int k = 0; k < int'(N); k++) begin
      p = int'(start) + k;
      if (p >= int'(N)) p = p - int'(N);
      for (int i = 0; i < int'(N); i++) begin
        if (!any && valid[i] && (i == p)) begin
          grant[i] = 1'b1;
          idx      = IW'(i);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter for NUM_REQ writeback requesters.
// Default: round-robin. With WB_ARB_FIXED_PRIO_EN defined: fixed priority,
// lowest index wins and no rotation pointer is kept.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned IDX_W   = 3
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_hold,
  output logic                      Write1,
  output logic [ADDR_W-1:0]         WriteReg1,
  output logic [DATA_W-1:0]         WriteData1,
  output logic [IDX_W-1:0]          grant_id
);

  logic [IDX_W-1:0]   start;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               accept;
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_data;

`ifdef WB_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDX_W-1:0] rr_ptr;
  assign start = rr_ptr;

  // Advance the pointer past the winner; hold it when nothing is granted.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
  end
`endif

  wb_port_arbiter_rr_picker #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_picker (
    .valid (req_valid),
    .start (start),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // RESET gates ready so nothing is accepted while the port is being cleared.
  assign accept    = pick_any & ~wb_hold & RESET;
  assign req_ready = accept ? pick_grant : '0;

  // One-hot mux of the winning requester's index and data.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_grant[i]) begin
        sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Write port register; index/data/id hold their value when idle or held.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Write1     <= 1'b0;
      WriteReg1  <= '0;
      WriteData1 <= '0;
      grant_id   <= '0;
    end else begin
      Write1 <= accept && (sel_reg != ADDR_W'(REG_ZERO));
      if (accept) begin
        WriteReg1  <= sel_reg;
        WriteData1 <= sel_data;
        grant_id   <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (3 requesters, 5-bit index, 32-bit data).
module tb_wb_port_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned IW = 3;
`ifdef WB_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            CLK;
  logic            RESET;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_reg;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wb_hold;
  logic            Write1;
  logic [AW-1:0]   WriteReg1;
  logic [DW-1:0]   WriteData1;
  logic [IW-1:0]   grant_id;

  int tests = 0;
  int fails = 0;

  wb_port_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .IDX_W   (IW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req_valid  (req_valid),
    .req_reg    (req_reg),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wb_hold    (wb_hold),
    .Write1     (Write1),
    .WriteReg1  (WriteReg1),
    .WriteData1 (WriteData1),
    .grant_id   (grant_id)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req_reg[i*AW +: AW]  = r;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    RESET = 1'b0; wb_hold = 1'b0; req_valid = 3'b111;
    req_reg = '0; req_data = '0;
    set_req(0, 5'd1, 32'hA0); set_req(1, 5'd2, 32'hA1); set_req(2, 5'd3, 32'hA2);
    @(negedge CLK); #1;
    tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL rst_ready: got %b want 000", req_ready); end
    tests++; if (Write1 !== 1'b0) begin fails++; $display("FAIL rst_write1: got %b want 0", Write1); end
    tests++; if (grant_id !== 3'd0) begin fails++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    tests++; if (WriteReg1 !== 5'd0 || WriteData1 !== 32'd0) begin fails++; $display("FAIL rst_port: got %0d/%h want 0/0", WriteReg1, WriteData1); end
    RESET = 1'b1; #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL rst_first_ready: got %b want 001", req_ready); end
    @(negedge CLK); #1;
    tests++; if (Write1 !== 1'b1 || grant_id !== 3'd0 || WriteData1 !== 32'hA0) begin fails++; $display("FAIL rst_first_grant: got %b/%0d/%h want 1/0/a0", Write1, grant_id, WriteData1); end
    tests++; if (req_ready !== (FIXED ? 3'b001 : 3'b010)) begin fails++; $display("FAIL rst_second_ready: got %b want %b", req_ready, FIXED ? 3'b001 : 3'b010); end
    @(negedge CLK); #1;
    tests++; if (grant_id !== (FIXED ? 3'd0 : 3'd1)) begin fails++; $display("FAIL rst_second_grant: got %0d want %0d", grant_id, FIXED ? 0 : 1); end
    // Asynchronous reset in the middle of a cycle with a write on the port.
    RESET = 1'b0; #1;
    tests++; if (Write1 !== 1'b0 || grant_id !== 3'd0 || req_ready !== 3'b000) begin fails++; $display("FAIL rst_midrun: got %b/%0d/%b want 0/0/000", Write1, grant_id, req_ready); end
    RESET = 1'b1; #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL rst_ptr_cleared: got %b want 001", req_ready); end
    req_valid = 3'b000;
    @(negedge CLK); #1;
    tests++; if (Write1 !== 1'b0) begin fails++; $display("FAIL rst_idle: got %b want 0", Write1); end
  endtask

  task automatic test_single();
    req_valid = 3'b010; set_req(1, 5'd7, 32'hDEADBEEF); #1;
    tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL single_ready: got %b want 010", req_ready); end
    @(negedge CLK); #1;
    req_valid = 3'b000;
    tests++; if (Write1 !== 1'b1 || WriteReg1 !== 5'd7 || WriteData1 !== 32'hDEADBEEF || grant_id !== 3'd1) begin
      fails++; $display("FAIL single_port: got %b/%0d/%h/%0d want 1/7/deadbeef/1", Write1, WriteReg1, WriteData1, grant_id); end
    @(negedge CLK); #1;
    tests++; if (Write1 !== 1'b0 || WriteReg1 !== 5'd7 || WriteData1 !== 32'hDEADBEEF || grant_id !== 3'd1) begin
      fails++; $display("FAIL single_idle_hold: got %b/%0d/%h/%0d want 0/7/deadbeef/1", Write1, WriteReg1, WriteData1, grant_id); end
  endtask

  task automatic test_round_robin();
    int e;
    int pe;
    RESET = 1'b0; #1; RESET = 1'b1;
    set_req(0, 5'd1, 32'hA0); set_req(1, 5'd2, 32'hA1); set_req(2, 5'd3, 32'hA2);
    req_valid = 3'b111; #1;
    pe = 0;
    for (int k = 0; k < 6; k++) begin
      e = FIXED ? 0 : (k % 3);
      tests++; if (req_ready !== 3'(1 << e)) begin fails++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 3'(1 << e)); end
      if (k == 0) begin
        tests++; if (Write1 !== 1'b0) begin fails++; $display("FAIL rr_write1[0]: got %b want 0", Write1); end
      end else begin
        tests++; if (Write1 !== 1'b1 || grant_id !== 3'(pe) || WriteData1 !== 32'hA0 + 32'(pe)) begin
          fails++; $display("FAIL rr_port[%0d]: got %b/%0d/%h want 1/%0d/%h", k, Write1, grant_id, WriteData1, pe, 32'hA0 + 32'(pe)); end
      end
      pe = e;
      @(negedge CLK); #1;
    end
    req_valid = 3'b000;
    tests++; if (Write1 !== 1'b1 || grant_id !== 3'(pe) || WriteReg1 !== 5'(pe + 1)) begin
      fails++; $display("FAIL rr_last: got %b/%0d/%0d want 1/%0d/%0d", Write1, grant_id, WriteReg1, pe, pe + 1); end
    @(negedge CLK); #1;
  endtask

  task automatic test_reg_zero();
    set_req(0, 5'd4, 32'h55); req_valid = 3'b001; #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL rz_pre_ready: got %b want 001", req_ready); end
    @(negedge CLK); #1;
    set_req(2, 5'd0, 32'h1234); req_valid = 3'b100; #1;
    tests++; if (req_ready !== 3'b100) begin fails++; $display("FAIL rz_ready: got %b want 100", req_ready); end
    @(negedge CLK); #1;
    tests++; if (Write1 !== 1'b0) begin fails++; $display("FAIL rz_write1: got %b want 0", Write1); end
    set_req(1, 5'd6, 32'h66); req_valid = 3'b011; #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL rz_ptr_wrap: got %b want 001", req_ready); end
    req_valid = 3'b000;
    @(negedge CLK); #1;
  endtask

  task automatic test_hold();
    wb_hold = 1'b1; set_req(0, 5'd10, 32'hCAFE); req_valid = 3'b001;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (req_ready !== 3'b000 || Write1 !== 1'b0) begin fails++; $display("FAIL hold[%0d]: got %b/%b want 000/0", c, req_ready, Write1); end
      @(negedge CLK);
    end
    wb_hold = 1'b0; #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL hold_release_ready: got %b want 001", req_ready); end
    @(negedge CLK); #1;
    req_valid = 3'b000; wb_hold = 1'b1; #1;
    tests++; if (Write1 !== 1'b1 || grant_id !== 3'd0 || WriteReg1 !== 5'd10 || WriteData1 !== 32'hCAFE) begin
      fails++; $display("FAIL hold_no_cancel: got %b/%0d/%0d/%h want 1/0/10/cafe", Write1, grant_id, WriteReg1, WriteData1); end
    @(negedge CLK); #1;
    tests++; if (Write1 !== 1'b0) begin fails++; $display("FAIL hold_after: got %b want 0", Write1); end
    wb_hold = 1'b0;
  endtask

  task automatic test_same_reg();
    int first;
    int second;
    logic [DW-1:0] d_second;
    first    = FIXED ? 0 : 1;
    second   = FIXED ? 1 : 0;
    d_second = (second == 0) ? 32'h111 : 32'h222;
    set_req(0, 5'd9, 32'h111); set_req(1, 5'd9, 32'h222); req_valid = 3'b011; #1;
    tests++; if (req_ready !== 3'(1 << first)) begin fails++; $display("FAIL same_ready1: got %b want %b", req_ready, 3'(1 << first)); end
    @(negedge CLK); #1;
    tests++; if (Write1 !== 1'b1 || grant_id !== 3'(first) || WriteReg1 !== 5'd9) begin
      fails++; $display("FAIL same_port1: got %b/%0d/%0d want 1/%0d/9", Write1, grant_id, WriteReg1, first); end
    req_valid = 3'(1 << second); #1;
    tests++; if (req_ready !== 3'(1 << second)) begin fails++; $display("FAIL same_ready2: got %b want %b", req_ready, 3'(1 << second)); end
    @(negedge CLK); #1;
    req_valid = 3'b000;
    tests++; if (Write1 !== 1'b1 || grant_id !== 3'(second) || WriteData1 !== d_second) begin
      fails++; $display("FAIL same_port2: got %b/%0d/%h want 1/%0d/%h", Write1, grant_id, WriteData1, second, d_second); end
    @(negedge CLK); #1;
    tests++; if (Write1 !== 1'b0 || WriteData1 !== d_second) begin fails++; $display("FAIL same_persist: got %b/%h want 0/%h", Write1, WriteData1, d_second); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reg_zero();
    test_hold();
    test_same_reg();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
